// File: rtl/data_mem_responder.sv
// Data-memory responder: target side of the CPU MEM-stage load/store port.
// Accepts one word-aligned request per handshake, waits WAIT_CYCLES, then
// performs the access and presents a registered response until it is taken.
module data_mem_responder #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned WAIT_CYCLES = 2,
    parameter logic [31:0] ADDR_BASE   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [3:0]  req_be,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int unsigned AW        = $clog2(DEPTH_WORDS);
    localparam logic [3:0]  WAIT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [3:0]  wait_cnt;

    logic        lat_we;
    logic [31:0] lat_addr;
    logic [3:0]  lat_be;
    logic [31:0] lat_wdata;

    logic        accept;
    logic        do_access;

    logic        acc_we;
    logic [31:0] acc_addr;
    logic [3:0]  acc_be;
    logic [31:0] acc_wdata;
    logic [32:0] acc_diff;
    logic [31:0] acc_word;
    logic        acc_err;
    logic [AW-1:0] acc_idx;

    logic [31:0] mem [DEPTH_WORDS];

    assign req_ready = (state == S_IDLE) && !rst;
    assign accept    = req_valid && req_ready;

    // Next-state decode and the strobe marking the edge that performs the access.
    always_comb begin
        state_next = state;
        do_access  = 1'b0;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (WAIT_CYCLES == 0) begin
                        do_access  = 1'b1;
                        state_next = S_RESP;
                    end else begin
                        state_next = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (wait_cnt == '0) begin
                    do_access  = 1'b1;
                    state_next = S_RESP;
                end
            end
            S_RESP: begin
                if (resp_valid && resp_ready) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Access operands: with zero wait states the access happens on the accept
    // edge itself, so the live request inputs are used instead of the latch.
    always_comb begin
        acc_we    = lat_we;
        acc_addr  = lat_addr;
        acc_be    = lat_be;
        acc_wdata = lat_wdata;
        if (state == S_IDLE) begin
            acc_we    = req_we;
            acc_addr  = req_addr;
            acc_be    = req_be;
            acc_wdata = req_wdata;
        end
        // Bit 32 of the widened difference is the borrow, i.e. addr < ADDR_BASE.
        acc_diff = {1'b0, acc_addr} - {1'b0, ADDR_BASE};
        acc_word = acc_diff[31:0] >> 2;
        acc_err  = (acc_addr[1:0] != 2'b00) || acc_diff[32] ||
                   (acc_word >= 32'(DEPTH_WORDS));
        acc_idx  = acc_word[AW-1:0];
    end

    // State register, request latch and wait-state counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            wait_cnt  <= '0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_be    <= '0;
            lat_wdata <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                lat_we    <= req_we;
                lat_addr  <= req_addr;
                lat_be    <= req_be;
                lat_wdata <= req_wdata;
                wait_cnt  <= WAIT_INIT;
            end else if ((state == S_WAIT) && (wait_cnt != '0)) begin
                wait_cnt <= wait_cnt - 4'd1;
            end
        end
    end

    // Registered response: loaded on the access edge, cleared on the handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else if (do_access) begin
            resp_valid <= 1'b1;
            resp_err   <= acc_err;
            resp_rdata <= (acc_err || acc_we) ? '0 : mem[acc_idx];
        end else if (resp_valid && resp_ready) begin
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end
    end

    // Byte-enabled store into the word array; contents survive reset.
    always_ff @(posedge clk) begin
        if (do_access && acc_we && !acc_err && !rst) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (acc_be[b]) begin
                    mem[acc_idx][8*b +: 8] <= acc_wdata[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: transaction-level reference
// model compared every cycle, directed scenarios with literal expectations,
// randomized traffic, and a second zero-wait-state instance for throughput.
module tb_data_mem_responder;

    localparam int unsigned T_DEPTH = 256;
    localparam int unsigned T_WAIT  = 2;
    localparam logic [31:0] T_BASE  = 32'h0000_0000;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [3:0]  req_be;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    logic        req_valid_z;
    logic        req_ready_z;
    logic        req_we_z;
    logic [31:0] req_addr_z;
    logic [3:0]  req_be_z;
    logic [31:0] req_wdata_z;
    logic        resp_valid_z;
    logic        resp_ready_z;
    logic [31:0] resp_rdata_z;
    logic        resp_err_z;

    int n_cmp  = 0;
    int n_fail = 0;

    data_mem_responder #(
        .DEPTH_WORDS(T_DEPTH),
        .WAIT_CYCLES(T_WAIT),
        .ADDR_BASE  (T_BASE)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_be    (req_be),
        .req_wdata (req_wdata),
        .resp_valid(resp_valid),
        .resp_ready(resp_ready),
        .resp_rdata(resp_rdata),
        .resp_err  (resp_err)
    );

    data_mem_responder #(
        .DEPTH_WORDS(16),
        .WAIT_CYCLES(0),
        .ADDR_BASE  (32'h0000_0100)
    ) u_dut_z (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid_z),
        .req_ready (req_ready_z),
        .req_we    (req_we_z),
        .req_addr  (req_addr_z),
        .req_be    (req_be_z),
        .req_wdata (req_wdata_z),
        .resp_valid(resp_valid_z),
        .resp_ready(resp_ready_z),
        .resp_rdata(resp_rdata_z),
        .resp_err  (resp_err_z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model (transaction level) ----------------
    logic [31:0] mmem [T_DEPTH];
    int unsigned edge_no = 0;
    bit          m_busy  = 0;
    bit          m_resp  = 0;
    int unsigned m_due;
    logic        m_we;
    logic [31:0] m_addr;
    logic [3:0]  m_be;
    logic [31:0] m_wd;
    logic [31:0] m_rdata;
    logic        m_err;

    task model_access();
        longint unsigned word;
        word    = (longint'(m_addr) - longint'(T_BASE)) / 4;
        m_err   = (m_addr % 4 != 0) || (longint'(m_addr) < longint'(T_BASE)) || (word >= T_DEPTH);
        m_rdata = '0;
        if (!m_err) begin
            if (m_we) begin
                for (int b = 0; b < 4; b++)
                    if (m_be[b]) mmem[word][8*b +: 8] = m_wd[8*b +: 8];
            end else begin
                m_rdata = mmem[word];
            end
        end
        m_busy = 0;
        m_resp = 1;
    endtask

    // Compare DUT outputs against the model every cycle, then advance the
    // model across the upcoming rising edge using the sampled inputs.
    always @(negedge clk) begin
        if (rst) begin
            m_busy = 0;
            m_resp = 0;
        end
        chk("req_ready",  32'(req_ready),  32'(!rst && !m_busy && !m_resp));
        chk("resp_valid", 32'(resp_valid), 32'(m_resp));
        chk("resp_rdata", resp_rdata,      m_resp ? m_rdata : 32'h0);
        chk("resp_err",   32'(resp_err),   32'(m_resp && m_err));
        edge_no++;
        if (!rst) begin
            if (m_resp) begin
                if (resp_ready) m_resp = 0;
            end else if (m_busy) begin
                if (edge_no == m_due) model_access();
            end else if (req_valid) begin
                m_we   = req_we;
                m_addr = req_addr;
                m_be   = req_be;
                m_wd   = req_wdata;
                m_due  = edge_no + T_WAIT;
                if (T_WAIT == 0) model_access();
                else m_busy = 1;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic txn(input logic we, input logic [31:0] a, input logic [3:0] be,
                       input logic [31:0] wd, output logic [31:0] rd, output logic er,
                       output int lat);
        bit ok;
        rd  = '0;
        er  = 1'b0;
        lat = 0;
        @(posedge clk); #1;
        req_valid  = 1'b1;
        req_we     = we;
        req_addr   = a;
        req_be     = be;
        req_wdata  = wd;
        resp_ready = 1'b1;
        ok = 0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (req_ready) ok = 1;
            else begin @(posedge clk); #1; end
        end
        chk("accept_timeout", 32'(ok), 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_we    = 1'($urandom);
        req_addr  = $urandom;
        req_wdata = $urandom;
        req_be    = 4'($urandom);
        if (!ok) return;
        lat = 1;
        ok  = 0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (resp_valid) begin
                ok = 1;
                rd = resp_rdata;
                er = resp_err;
            end else begin
                @(posedge clk); #1;
                lat++;
            end
        end
        chk("resp_timeout", 32'(ok), 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic z_txn(input logic we, input logic [31:0] a, input logic [3:0] be,
                         input logic [31:0] wd, output logic [31:0] rd, output logic er);
        @(posedge clk); #1;
        req_valid_z  = 1'b1;
        req_we_z     = we;
        req_addr_z   = a;
        req_be_z     = be;
        req_wdata_z  = wd;
        resp_ready_z = 1'b1;
        @(negedge clk);
        chk("z_req_ready", 32'(req_ready_z), 32'd1);
        @(posedge clk); #1;
        req_valid_z = 1'b0;
        @(negedge clk);
        chk("z_resp_valid", 32'(resp_valid_z), 32'd1);
        rd = resp_rdata_z;
        er = resp_err_z;
        @(posedge clk); #1;
        @(negedge clk);
        chk("z_idle_ready", 32'(req_ready_z), 32'd1);
        chk("z_idle_valid", 32'(resp_valid_z), 32'd0);
    endtask

    function automatic logic [31:0] rand_addr();
        int unsigned r;
        int unsigned w;
        logic [31:0] a;
        r = $urandom_range(0, 9);
        w = $urandom_range(0, 32);
        a = T_BASE + 4 * ((w == 32) ? 255 : w);
        if (r == 0) a = a | 32'($urandom_range(1, 3));
        if (r == 1) a = T_BASE + 4 * T_DEPTH + 4 * $urandom_range(0, 1000);
        if (r == 2) a = $urandom | 32'h8000_0000;
        return a;
    endfunction

    // ---------------- main sequence ----------------
    logic [31:0] rd;
    logic [31:0] rd0;
    logic        er;
    int          lat;
    int          acc;

    initial begin
        rst = 1'b0;
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_be = '0; req_wdata = '0;
        resp_ready = 1'b0;
        req_valid_z = 1'b0; req_we_z = 1'b0; req_addr_z = '0; req_be_z = '0; req_wdata_z = '0;
        resp_ready_z = 1'b0;
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready",  32'(req_ready),  32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_rdata", resp_rdata,      32'd0);
        chk("rst_resp_err",   32'(resp_err),   32'd0);
        @(posedge clk); #1 rst = 1'b0;

        // Preload the words used by later traffic so no load reads undefined data.
        for (int i = 0; i < 32; i++) txn(1'b1, T_BASE + 4 * i, 4'hF, $urandom, rd, er, lat);
        txn(1'b1, T_BASE + 4 * 255, 4'hF, 32'h600D_CAFE, rd, er, lat);
        txn(1'b1, 32'h40, 4'hF, 32'h0BAD_F00D, rd, er, lat);

        // Basic store then load with latency.
        txn(1'b1, 32'h10, 4'hF, 32'hDEAD_BEEF, rd, er, lat);
        chk("store_latency", 32'(lat), 32'd3);
        chk("store_err",     32'(er),  32'd0);
        chk("store_rdata",   rd,       32'd0);
        txn(1'b0, 32'h10, 4'h0, 32'h0, rd, er, lat);
        chk("load_latency", 32'(lat), 32'd3);
        chk("load_rdata",   rd,       32'hDEAD_BEEF);

        // Byte enables, and a store with no enables leaves the word alone.
        txn(1'b1, 32'h20, 4'hF,    32'h1122_3344, rd, er, lat);
        txn(1'b1, 32'h20, 4'b0101, 32'hAABB_CCDD, rd, er, lat);
        txn(1'b0, 32'h20, 4'h0,    32'h0,         rd, er, lat);
        chk("be_merge", rd, 32'h11BB_33DD);
        txn(1'b1, 32'h20, 4'h0, 32'hFFFF_FFFF, rd, er, lat);
        chk("be_zero_err", 32'(er), 32'd0);
        txn(1'b0, 32'h20, 4'h0, 32'h0, rd, er, lat);
        chk("be_zero_keep", rd, 32'h11BB_33DD);

        // Error cases.
        txn(1'b0, 32'h22, 4'h0, 32'h0, rd, er, lat);
        chk("misalign_err",   32'(er), 32'd1);
        chk("misalign_rdata", rd,      32'd0);
        txn(1'b1, T_BASE + 4 * T_DEPTH, 4'hF, 32'h1234_5678, rd, er, lat);
        chk("oor_err", 32'(er), 32'd1);
        txn(1'b0, T_BASE + 4 * (T_DEPTH - 1), 4'h0, 32'h0, rd, er, lat);
        chk("last_word_keep", rd, 32'h600D_CAFE);
        chk("last_word_err",  32'(er), 32'd0);

        // Back-pressure: response must hold while resp_ready is low.
        @(posedge clk); #1;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10; resp_ready = 1'b0;
        @(negedge clk);
        chk("bp_accept_ready", 32'(req_ready), 32'd1);
        @(posedge clk); #1 req_valid = 1'b0;
        acc = 0;
        for (int i = 0; i < 20 && !resp_valid; i++) begin
            @(negedge clk);
            if (!resp_valid) begin @(posedge clk); #1; end
        end
        chk("bp_resp_seen", 32'(resp_valid), 32'd1);
        rd0 = resp_rdata;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            chk("bp_valid", 32'(resp_valid), 32'd1);
            chk("bp_rdata", resp_rdata,      32'hDEAD_BEEF);
            chk("bp_hold",  resp_rdata,      rd0);
            chk("bp_err",   32'(resp_err),   32'd0);
            chk("bp_ready", 32'(req_ready),  32'd0);
        end
        @(posedge clk); #1 resp_ready = 1'b1;
        @(negedge clk);
        chk("bp_pre_hs_valid", 32'(resp_valid), 32'd1);
        @(negedge clk);
        chk("bp_post_valid", 32'(resp_valid), 32'd0);
        chk("bp_post_ready", 32'(req_ready),  32'd1);

        // Reset one edge after a store is accepted: the store never lands.
        @(posedge clk); #1;
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h40; req_be = 4'hF;
        req_wdata = 32'h5555_5555; resp_ready = 1'b1;
        @(negedge clk);
        chk("rw_accept_ready", 32'(req_ready), 32'd1);
        @(posedge clk); #1 req_valid = 1'b0;
        @(posedge clk); #1 rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("rw_no_valid", 32'(resp_valid), 32'd0);
            if (i == 2) begin @(posedge clk); #1 rst = 1'b0; end
        end
        txn(1'b0, 32'h40, 4'h0, 32'h0, rd, er, lat);
        chk("rw_prior_value", rd, 32'h0BAD_F00D);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 1500; i++) begin
            @(posedge clk); #1;
            rst        = ($urandom_range(0, 199) == 0);
            req_valid  = ($urandom_range(0, 2) != 0);
            req_we     = 1'($urandom);
            req_addr   = rand_addr();
            req_be     = 4'($urandom);
            req_wdata  = $urandom;
            resp_ready = ($urandom_range(0, 3) != 0);
        end
        @(posedge clk); #1;
        rst = 1'b0; req_valid = 1'b0; resp_ready = 1'b1;
        repeat (10) @(posedge clk);

        // Zero-wait-state instance: base 0x100, 16 words.
        z_txn(1'b1, 32'h100, 4'hF, 32'hCAFE_F00D, rd, er);
        chk("z_store_err",   32'(er), 32'd0);
        chk("z_store_rdata", rd,      32'd0);
        @(posedge clk); #1;
        req_valid_z = 1'b1; req_we_z = 1'b0; req_addr_z = 32'h100; resp_ready_z = 1'b1;
        acc = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("z_stream_ready", 32'(req_ready_z),  32'(i % 2 == 0));
            chk("z_stream_valid", 32'(resp_valid_z), 32'(i % 2 == 1));
            if (resp_valid_z) chk("z_stream_rdata", resp_rdata_z, 32'hCAFE_F00D);
            if (req_valid_z && req_ready_z) acc++;
            @(posedge clk); #1;
        end
        req_valid_z = 1'b0;
        chk("z_accept_count", 32'(acc), 32'd10);
        @(negedge clk);
        z_txn(1'b0, 32'h0FC, 4'h0, 32'h0, rd, er);
        chk("z_below_base_err", 32'(er), 32'd1);
        chk("z_below_base_rd",  rd,      32'd0);
        z_txn(1'b0, 32'h140, 4'h0, 32'h0, rd, er);
        chk("z_oor_err", 32'(er), 32'd1);
        z_txn(1'b0, 32'h100, 4'h0, 32'h0, rd, er);
        chk("z_load_err", 32'(er), 32'd0);
        chk("z_load_rd",  rd,      32'hCAFE_F00D);

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
        $fatal(1, "watchdog");
    end

endmodule
